// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and round-robin index search for FIFO port arbiters.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    localparam int RR_MAX = 32;

    // Returns {found, index}: first set bit of valid[n-1:0] scanning from last+1 with wrap.
    function automatic logic [5:0] next_rr_index(input logic [RR_MAX-1:0] valid, input int n, input int last);
        logic [5:0] r;
        logic [4:0] idx;
        r = '0;
        for (int i = RR_MAX; i >= 1; i--) begin
            idx = 5'((last + i) % n);
            if (i <= n && valid[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_priority_pick: combinational round-robin pick of the next requester after last_i.
module rr_priority_pick import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic               found_o,
    output logic [ID_W-1:0]    pick_o
);

    logic [5:0] res;

    assign res     = next_rr_index(RR_MAX'(req_i), NUM_REQ, int'(last_i));
    assign found_o = res[5];
    assign pick_o  = ID_W'(res[4:0]);

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter import fifo_arb_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int BURST_W   = $clog2(MAX_BURST + 1),
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          write_clk,
    input  logic                          write_reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d, last_owner_q, last_owner_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               found, xfer, end_burst;
    logic [ID_W-1:0]    pick;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .last_i  (last_owner_q),
        .found_o (found),
        .pick_o  (pick)
    );

    // Write enable is gated by fifo_full in the same cycle, so overflow cannot occur.
    always_comb begin
        xfer            = (state_q == ARB_BURST) && req_valid[owner_q] && !fifo_full;
        req_ready       = xfer ? NUM_REQ'(1) << owner_q : '0;
        fifo_write_en   = xfer;
        fifo_write_data = xfer ? words[owner_q] : '0;
        busy            = state_q == ARB_BURST;
        grant_id        = owner_q;
        end_burst       = xfer ? (req_last[owner_q] || burst_cnt_q + 1'b1 == BURST_W'(MAX_BURST))
                               : !req_valid[owner_q];
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        burst_cnt_d     = burst_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (found) begin
                state_d     = ARB_BURST;
                owner_d     = pick;
                burst_cnt_d = '0;
            end
        end else begin
            if (xfer) burst_cnt_d = burst_cnt_q + 1'b1;
            if (end_burst) begin
                state_d      = ARB_IDLE;
                last_owner_d = owner_q;
            end
        end
    end

    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= ID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed vector table, burst sequences and a random FIFO scoreboard.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        write_reset_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        fifo_full, fifo_write_en, busy;
    logic [7:0]  fifo_write_data;
    logic [1:0]  grant_id;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic        we;
        logic [7:0]  wd;
        logic [1:0]  gid;
        logic        bsy;
    } vec_t;

    vec_t       tbl [24];
    int         cnt [4];
    int         seq [4];
    int         rd [4];
    int         acc;
    logic [7:0] fq [$];
    logic [3:0] s_rdy;
    logic       s_we;
    logic [7:0] s_wd;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .write_clk       (clk),
        .write_reset_n   (write_reset_n),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check;
        logic [7:0] w;
        int id;
        w  = fq.pop_front();
        id = int'(w[7:6]);
        chk("t6_order", {26'd0, w[5:0]}, {26'd0, 6'(rd[id])});
        rd[id]++;
    endtask

    initial begin
        tbl[0]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000_1100, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000_1100, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1};
        tbl[2]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000_2200, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1};
        tbl[3]  = '{4'b0010, 4'b0010, 1'b0, 32'h0000_3300, 4'b0010, 1'b1, 8'h33, 2'd1, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A1_0000, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A1_0000, 4'b0100, 1'b1, 8'hA1, 2'd2, 1'b1};
        tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A2_0000, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1};
        for (int i = 8; i <= 12; i++)
            tbl[i] = '{4'b0100, 4'b0000, 1'b1, 32'h00A3_0000, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1};
        tbl[13] = '{4'b0100, 4'b0000, 1'b0, 32'h00A3_0000, 4'b0100, 1'b1, 8'hA3, 2'd2, 1'b1};
        tbl[14] = '{4'b0100, 4'b0000, 1'b0, 32'h00A4_0000, 4'b0100, 1'b1, 8'hA4, 2'd2, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[16] = '{4'b1000, 4'b0000, 1'b0, 32'hD100_0000, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[17] = '{4'b1001, 4'b0000, 1'b0, 32'hD100_0001, 4'b1000, 1'b1, 8'hD1, 2'd3, 1'b1};
        tbl[18] = '{4'b0001, 4'b0000, 1'b0, 32'hD200_0001, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1};
        tbl[19] = '{4'b1001, 4'b0000, 1'b0, 32'hD200_0001, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
        tbl[20] = '{4'b1001, 4'b0001, 1'b0, 32'hD200_0001, 4'b0001, 1'b1, 8'h01, 2'd0, 1'b1};
        tbl[21] = '{4'b1000, 4'b0000, 1'b0, 32'hD200_0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[22] = '{4'b1000, 4'b1000, 1'b0, 32'hD200_0000, 4'b1000, 1'b1, 8'hD2, 2'd3, 1'b1};
        tbl[23] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};

        // Reset state, then reset asserted mid-burst without any clock edge.
        write_reset_n = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick;
        tick;
        #4;
        chk("rst_we", fifo_write_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", fifo_write_data, 0);
        chk("rst_gid", grant_id, 0);
        tick;
        write_reset_n = 1'b1;
        tick;
        req_valid = 4'b0100;
        req_data  = 32'h00C0_00A0;
        #4;
        chk("t1_idle_busy", busy, 0);
        tick;
        #3;
        chk("t1_grant2", grant_id, 2);
        chk("t1_we2", fifo_write_en, 1);
        write_reset_n = 1'b0;
        #1;
        chk("t1_async_we", fifo_write_en, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_gid", grant_id, 0);
        chk("t1_async_ready", req_ready, 0);
        chk("t1_async_data", fifo_write_data, 0);
        tick;
        write_reset_n = 1'b1;
        req_valid = 4'b0101;
        #4;
        chk("t1_rel_busy", busy, 0);
        tick;
        #4;
        chk("t1_first_gid", grant_id, 0);
        chk("t1_first_ready", req_ready, 4'b0001);
        chk("t1_first_data", fifo_write_data, 8'hA0);
        tick;
        req_valid = '0;
        tick;
        tick;

        // Directed table: single burst with last, full stall, owner drop and re-serve order.
        for (int i = 0; i < 24; i++) begin
            req_valid = tbl[i].v;
            req_last  = tbl[i].l;
            fifo_full = tbl[i].f;
            req_data  = tbl[i].d;
            #4;
            chk($sformatf("row%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("row%0d_we", i), fifo_write_en, tbl[i].we);
            chk($sformatf("row%0d_data", i), fifo_write_data, tbl[i].wd);
            chk($sformatf("row%0d_gid", i), grant_id, tbl[i].gid);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            tick;
        end

        // All four requesters continuously valid: full bursts of 4 in order 0,1,2,3,0.
        req_last  = '0;
        fifo_full = 1'b0;
        for (int b = 0; b < 5; b++) begin
            int o;
            o = b % 4;
            req_valid = 4'b1111;
            for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 16 + cnt[i]);
            #4;
            chk($sformatf("t3_bubble%0d", b), {busy, fifo_write_en}, 0);
            tick;
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 16 + cnt[i]);
                #4;
                chk($sformatf("t3_b%0d_gid", b), grant_id, o);
                chk($sformatf("t3_b%0d_we", b), fifo_write_en, 1);
                chk($sformatf("t3_b%0d_data", b), fifo_write_data, 8'(o * 16 + cnt[o]));
                tick;
                cnt[o]++;
            end
        end
        req_valid = '0;
        tick;
        tick;

        // Random traffic against a depth-4 FIFO model with a random reader.
        acc = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = $urandom_range(0, 3) != 0;
                req_last[i]  = $urandom_range(0, 3) == 0;
                req_data[i*8 +: 8] = {2'(i), 6'(seq[i])};
            end
            fifo_full = fq.size() >= 4;
            #4;
            s_rdy = req_ready;
            s_we  = fifo_write_en;
            s_wd  = fifo_write_data;
            chk("t6_onehot", {31'd0, $onehot0(s_rdy) && ((s_rdy & ~req_valid) == 4'b0)}, 1);
            chk("t6_we", s_we, |s_rdy);
            chk("t6_no_ovf", s_we && fifo_full, 0);
            for (int i = 0; i < 4; i++)
                if (s_rdy[i]) chk("t6_data", s_wd, {2'(i), 6'(seq[i])});
            @(posedge clk);
            if (s_we) begin
                fq.push_back(s_wd);
                acc++;
            end
            for (int i = 0; i < 4; i++) if (s_rdy[i]) seq[i]++;
            if (fq.size() > 0 && $urandom_range(0, 1) == 1) pop_check();
            #1;
        end
        req_valid = '0;
        fifo_full = 1'b0;
        while (fq.size() > 0) pop_check();
        for (int i = 0; i < 4; i++) chk($sformatf("t6_count%0d", i), rd[i], seq[i]);
        chk("t6_progress", {31'd0, acc >= 200}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
